// File: rtl/zbus_pkg.sv
// Shared defaults and expectation-entry layout for the zbus checker.
// An entry packs {bus, msk, dly}, with dly in the least significant bits.
package zbus_pkg;

    localparam int BW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 16;

    localparam int ENT_DLY_OFS = 0;

    function automatic int ent_width(input int bw, input int dw);
        return 2 * bw + dw;
    endfunction

    function automatic int ent_msk_ofs(input int dw);
        return dw;
    endfunction

    function automatic int ent_bus_ofs(input int bw, input int dw);
        return dw + bw;
    endfunction

endpackage

// File: rtl/zbus_fifo.sv
// Synchronous FIFO for the expectation queue; a written entry is readable
// from the following cycle only (no write-to-read bypass).
module zbus_fifo #(
    parameter int W = 8,
    parameter int LN = 4,
    localparam int LNL = $clog2(LN)
) (
    input  logic           z_clk,
    input  logic           z_rst,
    input  logic           wr,
    input  logic [W-1:0]   wdata,
    input  logic           rd,
    output logic [W-1:0]   rdata,
    output logic           full,
    output logic           empty,
    output logic [LNL:0]   count
);

    logic [W-1:0]   mem_q [LN];
    logic [W-1:0]   mem_d [LN];
    logic [LNL-1:0] wr_ptr_q, wr_ptr_d;
    logic [LNL-1:0] rd_ptr_q, rd_ptr_d;
    logic [LNL:0]   count_q, count_d;
    logic           do_wr, do_rd;

    assign full  = (count_q == (LNL+1)'(LN));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    // Pointers wrap naturally because LN is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + LNL'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + LNL'(1);
        end
        count_d = count_q + (LNL+1)'(do_wr) - (LNL+1)'(do_rd);
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/zbus_checker.sv
// zbus sink/checker: acknowledges transfers after a per-entry delay and counts
// masked mismatches. Define ZBUS_CHECKER_STALL_EN to stall the bus while empty.
module zbus_checker
    import zbus_pkg::*;
#(
    parameter int BW = BW_DEF,
    parameter int LN = 4,
    localparam int LNL = $clog2(LN),
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          z_clk,
    input  logic          z_rst,
    input  logic          z_vld,
    input  logic [BW-1:0] z_bus,
    output logic          z_ack,
    input  logic          e_vld,
    input  logic [BW-1:0] e_bus,
    input  logic [BW-1:0] e_msk,
    input  logic [DW-1:0] e_dly,
    output logic          e_rdy,
    output logic [LNL:0]  st_cnt,
    output logic [CW-1:0] st_trn,
    output logic [CW-1:0] st_err,
    output logic [CW-1:0] st_unx,
    output logic          st_mis
);

    localparam int EW      = ent_width(BW, DW);
    localparam int MSK_OFS = ent_msk_ofs(DW);
    localparam int BUS_OFS = ent_bus_ofs(BW, DW);

    logic [EW-1:0] ent_in, head;
    logic [BW-1:0] head_bus, head_msk;
    logic [DW-1:0] head_dly;
    logic          q_full, q_empty, q_wr, q_rd;
    logic          z_trn, mismatch;

    logic [DW-1:0] dly_q, dly_d;
    logic [CW-1:0] st_trn_q, st_trn_d;
    logic [CW-1:0] st_err_q, st_err_d;
    logic [CW-1:0] st_unx_q, st_unx_d;
    logic          st_mis_q, st_mis_d;

    assign ent_in   = {e_bus, e_msk, e_dly};
    assign head_bus = head[BUS_OFS +: BW];
    assign head_msk = head[MSK_OFS +: BW];
    assign head_dly = head[ENT_DLY_OFS +: DW];

    assign e_rdy = !q_full;
    assign q_wr  = e_vld && e_rdy;
    assign z_trn = z_vld && z_ack;
    assign q_rd  = z_trn && !q_empty;

    zbus_fifo #(
        .W  (EW),
        .LN (LN)
    ) u_fifo (
        .z_clk (z_clk),
        .z_rst (z_rst),
        .wr    (q_wr),
        .wdata (ent_in),
        .rd    (q_rd),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (st_cnt)
    );

    // Acknowledge depends only on registered state, never on z_vld.
    always_comb begin
`ifdef ZBUS_CHECKER_STALL_EN
        z_ack = 1'b0;
`else
        z_ack = 1'b1;
`endif
        if (!q_empty) begin
            z_ack = (dly_q == head_dly);
        end
    end

    assign mismatch = |((z_bus ^ head_bus) & head_msk);

    always_comb begin
        dly_d    = dly_q;
        st_trn_d = st_trn_q;
        st_err_d = st_err_q;
        st_unx_d = st_unx_q;
        st_mis_d = 1'b0;
        if (!z_vld || z_trn) begin
            dly_d = '0;
        end else if (dly_q != '1) begin
            dly_d = dly_q + DW'(1);
        end
        if (z_trn && st_trn_q != '1) begin
            st_trn_d = st_trn_q + CW'(1);
        end
        if (q_rd && mismatch) begin
            st_mis_d = 1'b1;
            if (st_err_q != '1) begin
                st_err_d = st_err_q + CW'(1);
            end
        end
        if (z_trn && q_empty) begin
            st_mis_d = 1'b1;
            if (st_unx_q != '1) begin
                st_unx_d = st_unx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            dly_q    <= '0;
            st_trn_q <= '0;
            st_err_q <= '0;
            st_unx_q <= '0;
            st_mis_q <= 1'b0;
        end else begin
            dly_q    <= dly_d;
            st_trn_q <= st_trn_d;
            st_err_q <= st_err_d;
            st_unx_q <= st_unx_d;
            st_mis_q <= st_mis_d;
        end
    end

    assign st_trn = st_trn_q;
    assign st_err = st_err_q;
    assign st_unx = st_unx_q;
    assign st_mis = st_mis_q;

endmodule

// File: tb/tb_zbus_checker.sv
// Self-checking bench for zbus_checker: a model queue of loaded expectations
// feeds a scoreboard of status results checked the cycle after each transfer.
module tb_zbus_checker;

    logic       z_clk, z_rst, z_vld, z_ack;
    logic [7:0] z_bus;
    logic       e_vld, e_rdy;
    logic [7:0] e_bus, e_msk, e_dly;
    logic [2:0] st_cnt;
    logic [15:0] st_trn, st_err, st_unx;
    logic       st_mis;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [7:0] bus;
        logic [7:0] msk;
        logic [7:0] dly;
    } ent_t;

    typedef struct {
        logic mis;
        int   trn;
        int   err;
        int   unx;
    } res_t;

    ent_t model_q[$];
    res_t sb_q[$];
    int   m_trn, m_err, m_unx;
    ent_t mon_head;
    res_t mon_res;
    logic mon_mis;

    zbus_checker dut (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .z_vld  (z_vld),
        .z_bus  (z_bus),
        .z_ack  (z_ack),
        .e_vld  (e_vld),
        .e_bus  (e_bus),
        .e_msk  (e_msk),
        .e_dly  (e_dly),
        .e_rdy  (e_rdy),
        .st_cnt (st_cnt),
        .st_trn (st_trn),
        .st_err (st_err),
        .st_unx (st_unx),
        .st_mis (st_mis)
    );

    initial z_clk = 1'b0;
    always #5 z_clk = ~z_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic zv, input logic [7:0] zb);
        z_vld = zv;
        z_bus = zb;
        @(posedge z_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b, input logic [7:0] m, input logic [7:0] d);
        checkOutput("load_rdy", e_rdy, 1);
        e_vld = 1'b1;
        e_bus = b;
        e_msk = m;
        e_dly = d;
        @(posedge z_clk);
        #1;
        e_vld = 1'b0;
    endtask

    task automatic wait_ack(input logic [7:0] b, input int exp_wait);
        int n;
        n = 0;
        z_vld = 1'b1;
        z_bus = b;
        #1;
        while (!z_ack && n < 300) begin
            @(posedge z_clk);
            #1;
            n++;
        end
        checkOutput("ack_wait", n, exp_wait);
        @(posedge z_clk);
        #1;
        z_vld = 1'b0;
    endtask

    // Model and scoreboard: status registers reflect the previous edge's transfer.
    always @(negedge z_clk) begin
        if (z_rst) begin
            model_q.delete();
            sb_q.delete();
            m_trn = 0;
            m_err = 0;
            m_unx = 0;
        end else begin
            checkOutput("st_cnt", st_cnt, model_q.size());
            checkOutput("e_rdy", e_rdy, (model_q.size() != 4) ? 1 : 0);
            if (sb_q.size() > 0) begin
                mon_res = sb_q.pop_front();
                checkOutput("st_mis", st_mis, mon_res.mis);
                checkOutput("st_trn", st_trn, mon_res.trn);
                checkOutput("st_err", st_err, mon_res.err);
                checkOutput("st_unx", st_unx, mon_res.unx);
            end else begin
                checkOutput("st_mis_idle", st_mis, 0);
            end
            if (z_vld && z_ack) begin
                m_trn++;
                if (model_q.size() == 0) begin
                    m_unx++;
                    mon_mis = 1'b1;
                end else begin
                    mon_head = model_q.pop_front();
                    mon_mis  = ((z_bus ^ mon_head.bus) & mon_head.msk) != 8'h00;
                    if (mon_mis) m_err++;
                end
                sb_q.push_back('{mon_mis, m_trn, m_err, m_unx});
            end
            if (e_vld && e_rdy) begin
                model_q.push_back('{e_bus, e_msk, e_dly});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        z_rst = 1'b1;
        z_vld = 1'b0;
        z_bus = '0;
        e_vld = 1'b0;
        e_bus = '0;
        e_msk = '0;
        e_dly = '0;
        repeat (2) @(posedge z_clk);
        #1;
        z_rst = 1'b0;
        checkOutput("rst_cnt", st_cnt, 0);
        checkOutput("rst_rdy", e_rdy, 1);
        checkOutput("rst_trn", st_trn, 0);
        checkOutput("rst_mis", st_mis, 0);
`ifdef ZBUS_CHECKER_STALL_EN
        checkOutput("rst_ack", z_ack, 0);
`else
        checkOutput("rst_ack", z_ack, 1);

        // Unexpected transfer on an empty queue.
        z_vld = 1'b1;
        z_bus = 8'h55;
        #1;
        checkOutput("unx_ack", z_ack, 1);
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b0, 8'h00);
        checkOutput("unx_cnt", st_unx, 1);
        checkOutput("unx_err", st_err, 0);
`endif

        // Delay of 3: ack low for three cycles.
        load(8'hA5, 8'hFF, 8'd3);
        checkOutput("dly_cnt1", st_cnt, 1);
        wait_ack(8'hA5, 3);
        applyStimulus(1'b0, 8'h00);
        checkOutput("dly_cnt0", st_cnt, 0);
        checkOutput("dly_err", st_err, 0);

        // Masked compare: low nibble checked, then high nibble checked.
        load(8'hF0, 8'h0F, 8'd0);
        wait_ack(8'hFF, 0);
        load(8'hF0, 8'hF0, 8'd0);
        wait_ack(8'hFF, 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("msk_err", st_err, 1);

        // Dropping z_vld restarts the wait.
        load(8'h3C, 8'hFF, 8'd2);
        z_vld = 1'b1;
        z_bus = 8'h3C;
        #1;
        checkOutput("rst_wait_ack", z_ack, 0);
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        wait_ack(8'h3C, 2);

        // Fill to full, pop while a load is held, then drain across the wrap.
        for (int i = 0; i < 4; i++) begin
            e_vld = 1'b1;
            e_bus = 8'(8'h11 * (i + 1));
            e_msk = 8'hFF;
            e_dly = 8'd0;
            @(posedge z_clk);
            #1;
        end
        e_bus = 8'h99;
        e_dly = 8'd1;
        z_vld = 1'b1;
        z_bus = 8'h11;
        checkOutput("full_rdy", e_rdy, 0);
        checkOutput("full_cnt", st_cnt, 4);
        checkOutput("full_ack", z_ack, 1);
        @(posedge z_clk);
        #1;
        z_vld = 1'b0;
        checkOutput("pop_rdy", e_rdy, 1);
        checkOutput("pop_cnt", st_cnt, 3);
        @(posedge z_clk);
        #1;
        e_vld = 1'b0;
        checkOutput("wrap_cnt", st_cnt, 4);
        wait_ack(8'h22, 0);
        wait_ack(8'h33, 0);
        wait_ack(8'h44, 0);
        wait_ack(8'h99, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("drain_cnt", st_cnt, 0);
        checkOutput("drain_err", st_err, 1);

        // Reset while stalled with three entries queued.
        load(8'h01, 8'hFF, 8'd200);
        load(8'h02, 8'hFF, 8'd200);
        load(8'h03, 8'hFF, 8'd200);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        checkOutput("stall_ack", z_ack, 0);
        z_rst = 1'b1;
        #1;
        checkOutput("mid_rst_cnt", st_cnt, 0);
        checkOutput("mid_rst_trn", st_trn, 0);
        checkOutput("mid_rst_err", st_err, 0);
        checkOutput("mid_rst_unx", st_unx, 0);
        checkOutput("mid_rst_mis", st_mis, 0);
        checkOutput("mid_rst_rdy", e_rdy, 1);
`ifdef ZBUS_CHECKER_STALL_EN
        checkOutput("mid_rst_ack", z_ack, 0);
`else
        checkOutput("mid_rst_ack", z_ack, 1);
`endif
        z_vld = 1'b0;
        @(posedge z_clk);
        #1;
        z_rst = 1'b0;
        @(posedge z_clk);
        #1;
`ifdef ZBUS_CHECKER_STALL_EN
        checkOutput("post_rst_ack", z_ack, 0);
        load(8'h5A, 8'hFF, 8'd0);
        checkOutput("first_load_ack", z_ack, 1);
`endif
        wait_ack(8'h5A, 0);
        repeat (3) applyStimulus(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/zbus_checker.md
Name: zbus_checker

Overview:
Parametrised zbus sink and checker for the bench. It holds a hardware queue of expected transfers (data, mask, acknowledge delay), loaded through a ready/valid port. It acknowledges incoming zbus transfers after the per-entry delay and compares masked data. Mismatches, unexpected transfers and totals are reported on saturating status counters, so a bench scoreboard can read pass/fail without text parsing.

Parameters:
BW, 8, zbus grouped-bus width
LN, 4, expected-transfer queue depth (power of two, >=2)
LNL, $clog2(LN), pointer width (derived, not to be overridden)
DW, 8, acknowledge-delay field width
CW, 16, status counter width

Ports:
z_clk  input  1  system clock
z_rst  input  1  reset, asynchronous, active-high
z_vld  input  1  zbus transfer valid
z_bus  input  BW  zbus grouped bus signals
z_ack  output  1  zbus transfer acknowledge
e_vld  input  1  expectation load valid
e_bus  input  BW  expected bus value
e_msk  input  BW  compare mask (1 = bit checked)
e_dly  input  DW  acknowledge delay, in z_vld-high cycles
e_rdy  output  1  expectation load ready
st_cnt  output  LNL+1  queue occupancy
st_trn  output  CW  completed zbus transfers
st_err  output  CW  masked data mismatches
st_unx  output  CW  transfers received with queue empty
st_mis  output  1  one-cycle pulse on any mismatch or unexpected transfer

Behaviour:
- Reset (async): queue flushed, pointers=0, st_cnt=0, st_trn/st_err/st_unx=0, st_mis=0, delay counter=0. Therefore e_rdy=1 and z_ack=1 (empty queue).
- Reset asserted mid-operation discards all queued entries and counts. No partial state survives.
- Load: e_rdy = (st_cnt != LN). An entry is written on the rising edge when e_vld & e_rdy.
- Load timing: a written entry becomes head-visible on the next cycle; there is no write-to-read bypass.
- Transfer: z_trn = z_vld & z_ack, sampled on the rising edge of z_clk.
- z_ack is combinational from registered state only; it never depends on z_vld.
  - queue non-empty: z_ack = (dly == head.dly)
  - queue empty: z_ack = 1
- Delay counter dly (DW bits):
  - increments when z_vld & !z_ack, saturating at all-ones;
  - clears on z_trn or when z_vld=0.
  - A low z_vld therefore restarts the wait.
  - head.dly=0 gives acknowledge in the same cycle z_vld rises.
- On z_trn with queue non-empty:
  - pop the head; st_trn+1;
  - if ((z_bus ^ head.bus) & head.msk) != 0: st_err+1 and st_mis=1 on the next cycle.
- On z_trn with queue empty: st_trn+1, st_unx+1, st_mis=1 on the next cycle.
- Simultaneous load and pop in one cycle: both take effect and st_cnt is unchanged.
- Load is blocked only when full: e_rdy=0 at full even if a pop occurs that cycle.
- Pointers wrap modulo LN. st_cnt is the true occupancy, range 0..LN.
- All status counters saturate at 2^CW-1 and never wrap.

Optional Feature:
ZBUS_CHECKER_STALL_EN
- defined: with the queue empty, z_ack=0, so the bus stalls until an expectation is loaded. st_unx stays 0 in this mode. The dly counter still runs but is irrelevant until an entry appears.
- undefined: empty-queue behaviour is as in Behaviour (acknowledge and count as unexpected).

Decomposition:
- Package zbus_pkg holds:
  - default BW/DW/CW localparams;
  - the packed expectation-entry layout {bus, msk, dly}, width 2*BW+DW, as a width function plus field-offset constants.
- Sub-module zbus_fifo: synchronous FIFO with parameters width and LN, ports wr/rd/full/empty/count, no bypass. The checker instantiates one zbus_fifo for the expectation queue.

Test Plan:
- Reset, no loads; z_vld=1, z_bus=8'h55 for 1 cycle -> z_ack=1 same cycle; st_trn=1, st_unx=1, st_mis pulses once, st_err=0.
- Load {bus=8'hA5, msk=8'hFF, dly=3}; hold z_vld=1, z_bus=8'hA5 -> z_ack low for 3 cycles, high on the 4th; st_trn=1, st_err=0, st_cnt 1 -> 0.
- Load {8'hF0, msk=8'h0F, dly=0}; send 8'hFF -> zero-cycle ack, st_err+1 (low nibble differs). Load {8'hF0, msk=8'hF0, dly=0}; send 8'hFF -> st_err unchanged (unmasked bits ignored).
- Load dly=2; z_vld high 1 cycle, low 1 cycle, then high -> counter restarts; ack on the 3rd cycle of the second assertion.
- Load LN=4 entries back-to-back -> e_rdy=0 after the 4th, st_cnt=4. Hold e_vld while one transfer pops -> e_rdy=1 the next cycle, 5th entry accepted, pointer wraps, all 5 compare correctly.
- Assert z_rst with 3 entries queued and z_vld stalled -> st_cnt=0, all counters 0, z_ack=1 immediately. With ZBUS_CHECKER_STALL_EN: z_ack=0 after reset until the first load.
